// File: rtl/btn_tx_pkg.sv
// Shared types and constants for the button-to-UART transmit scheduler.
package btn_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_CR,
        ST_LF
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/btn_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: the first set request at or after ptr wins, wrapping at N-1.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_tx_scheduler.sv
// Queues debounced button presses and sends one byte per press to a UART transmitter.
// Define BTN_TX_CRLF_EN to follow each button byte with CR and LF.
module btn_tx_scheduler
    import btn_tx_pkg::*;
#(
    parameter int         N_REQ     = 4,
    parameter logic [7:0] BASE_CHAR = 8'h30
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_tick,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             drop_tick
);

    localparam int PW = $clog2(N_REQ);

    state_t           state;
    logic [N_REQ-1:0] pending;
    logic [PW-1:0]    rr_ptr;
    logic [N_REQ-1:0] arb_gnt;
    logic             arb_valid;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    ptr_next;
    logic [N_REQ-1:0] clr;
`ifdef BTN_TX_CRLF_EN
    logic [1:0]       phase;
`endif

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .req   (pending),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_gnt[i]) win_idx = PW'(i);
    end

    assign ptr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign clr      = (state == ST_IDLE && arb_valid) ? arb_gnt : '0;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state     <= ST_IDLE;
            pending   <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            drop_tick <= 1'b0;
`ifdef BTN_TX_CRLF_EN
            phase     <= 2'd0;
`endif
        end else begin
            // A fresh tick beats the grant clear; it only counts as a drop if it is not being granted now
            pending   <= (pending & ~clr) | req_tick;
            drop_tick <= |(req_tick & pending & ~clr);
            tx_start  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant    <= arb_gnt;
                        tx_data  <= BASE_CHAR + 8'(win_idx);
                        rr_ptr   <= ptr_next;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_START;
`ifdef BTN_TX_CRLF_EN
                        phase    <= 2'd0;
`endif
                    end
                end
                ST_START, ST_CR, ST_LF: state <= ST_WAIT;
                ST_WAIT: begin
                    if (tx_done) begin
`ifdef BTN_TX_CRLF_EN
                        if (phase == 2'd0) begin
                            phase    <= 2'd1;
                            tx_data  <= CHAR_CR;
                            tx_start <= 1'b1;
                            state    <= ST_CR;
                        end else if (phase == 2'd1) begin
                            phase    <= 2'd2;
                            tx_data  <= CHAR_LF;
                            tx_start <= 1'b1;
                            state    <= ST_LF;
                        end else begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
`else
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_tx_scheduler.sv
// Scoreboard bench for btn_tx_scheduler: expected bytes/grants queued at stimulus, checked at tx_start.
module tb_btn_tx_scheduler;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic [3:0] req_tick   = 4'b0000;
    logic       tx_done    = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] grant;
    logic       busy;
    logic       drop_tick;

`ifdef BTN_TX_CRLF_EN
    localparam int BPT = 3;
`else
    localparam int BPT = 1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    int drop_cnt = 0;

    logic [7:0] exp_q[$];
    logic [3:0] exp_g_q[$];

    btn_tx_scheduler #(.N_REQ(4), .BASE_CHAR(8'h30)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .req_tick   (req_tick),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .grant      (grant),
        .busy       (busy),
        .drop_tick  (drop_tick)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) begin
        if (tx_start) start_cnt++;
        if (drop_tick) drop_cnt++;
    end

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push_req(input int idx);
        exp_q.push_back(8'h30 + 8'(idx));
        exp_g_q.push_back(4'(1 << idx));
`ifdef BTN_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_g_q.push_back(4'(1 << idx));
        exp_q.push_back(8'h0A);
        exp_g_q.push_back(4'(1 << idx));
`endif
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (drop_tick !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", drop_tick); end
        reset = 1'b0;
        steps(3);
        n_cmp++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b tx_start=%b want 0/0", busy, tx_start); end
    endtask

    task automatic test_single();
        logic [7:0] e;
        logic [3:0] eg;
        bit ok;
        push_req(2);
        req_tick = 4'b0100;
        step();
        req_tick = 4'b0000;
        n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_cycle1: tx_start=%b want 0", tx_start); end
        step();
        e = exp_q.pop_front();
        eg = exp_g_q.pop_front();
        n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_latency: tx_start=%b want 1 at cycle 2", tx_start); end
        n_cmp++; if (tx_data !== e) begin n_err++; $display("FAIL single_data: got %h want %h", tx_data, e); end
        n_cmp++; if (grant !== eg) begin n_err++; $display("FAIL single_grant: got %b want %b", grant, eg); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n_cmp++; if (tx_start !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_start_len: tx_start=%b busy=%b want 0/1", tx_start, busy); end
        steps(9);
        n_cmp++; if (busy !== 1'b1 || grant !== eg) begin n_err++; $display("FAIL single_done_in_start: busy=%b grant=%b want 1/%b", busy, grant, eg); end
        pulse_done();
`ifdef BTN_TX_CRLF_EN
        while (exp_q.size() > 0) begin
            wait_start(50, ok);
            e = exp_q.pop_front();
            eg = exp_g_q.pop_front();
            n_cmp++; if (!ok || tx_data !== e || grant !== eg) begin n_err++; $display("FAIL single_crlf: ok=%0b data=%h grant=%b want %h/%b", ok, tx_data, grant, e, eg); end
            step();
            pulse_done();
        end
`endif
        n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_err++; $display("FAIL single_idle: busy=%b grant=%b want 0/0000", busy, grant); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] e;
        logic [3:0] eg;
        bit ok;
        int s0;
        do_reset();
        s0 = start_cnt;
        push_req(0);
        push_req(1);
        push_req(3);
        req_tick = 4'b1011;
        step();
        req_tick = 4'b0000;
        while (exp_q.size() > 0) begin
            wait_start(50, ok);
            e = exp_q.pop_front();
            eg = exp_g_q.pop_front();
            n_cmp++; if (!ok || tx_data !== e || grant !== eg) begin n_err++; $display("FAIL simul_byte: ok=%0b data=%h grant=%b want %h/%b", ok, tx_data, grant, e, eg); end
            steps(2);
            pulse_done();
        end
        steps(20);
        n_cmp++; if (start_cnt - s0 != 3 * BPT) begin n_err++; $display("FAIL simul_starts: got %0d want %0d", start_cnt - s0, 3 * BPT); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL simul_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_fairness();
        logic [7:0] e;
        logic [3:0] eg;
        bit ok;
        int nbtn;
        int cnt[4];
        do_reset();
        nbtn = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        push_req(0);
        req_tick = 4'b1111;
        step();
        req_tick = 4'b0000;
        while (exp_q.size() > 0) begin
            wait_start(50, ok);
            e = exp_q.pop_front();
            eg = exp_g_q.pop_front();
            n_cmp++; if (!ok || tx_data !== e || grant !== eg) begin n_err++; $display("FAIL fair_byte: ok=%0b data=%h grant=%b want %h/%b", ok, tx_data, grant, e, eg); end
            if (e >= 8'h30 && e < 8'h34) begin
                nbtn++;
                for (int i = 0; i < 4; i++) if (grant[i]) cnt[i]++;
                if (nbtn < 20) begin
                    req_tick = 4'b1111;
                    push_req(nbtn % 4);
                end
            end
            step();
            req_tick = 4'b0000;
            step();
            pulse_done();
        end
        n_cmp++; if (nbtn != 20) begin n_err++; $display("FAIL fair_count: got %0d want 20", nbtn); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cnt[i] != 5) begin n_err++; $display("FAIL fair_share%0d: got %0d want 5", i, cnt[i]); end
        end
        do_reset();
    endtask

    task automatic test_merge();
        logic [7:0] e;
        logic [3:0] eg;
        bit ok;
        int s0;
        int d0;
        do_reset();
        s0 = start_cnt;
        d0 = drop_cnt;
        push_req(0);
        push_req(1);
        req_tick = 4'b0011;
        step();
        req_tick = 4'b0000;
        wait_start(50, ok);
        e = exp_q.pop_front();
        eg = exp_g_q.pop_front();
        n_cmp++; if (!ok || tx_data !== e || grant !== eg) begin n_err++; $display("FAIL merge_first: ok=%0b data=%h grant=%b want %h/%b", ok, tx_data, grant, e, eg); end
        step();
        req_tick = 4'b0010;
        step();
        req_tick = 4'b0000;
        steps(2);
        req_tick = 4'b0010;
        step();
        req_tick = 4'b0000;
        steps(2);
        n_cmp++; if (drop_cnt - d0 != 2) begin n_err++; $display("FAIL merge_drops: got %0d want 2", drop_cnt - d0); end
        pulse_done();
        while (exp_q.size() > 0) begin
            wait_start(50, ok);
            e = exp_q.pop_front();
            eg = exp_g_q.pop_front();
            n_cmp++; if (!ok || tx_data !== e || grant !== eg) begin n_err++; $display("FAIL merge_byte: ok=%0b data=%h grant=%b want %h/%b", ok, tx_data, grant, e, eg); end
            step();
            pulse_done();
        end
        steps(20);
        n_cmp++; if (start_cnt - s0 != 2 * BPT) begin n_err++; $display("FAIL merge_starts: got %0d want %0d", start_cnt - s0, 2 * BPT); end
        n_cmp++; if (drop_cnt - d0 != 2) begin n_err++; $display("FAIL merge_drops_total: got %0d want 2", drop_cnt - d0); end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int s0;
        do_reset();
        req_tick = 4'b0001;
        step();
        req_tick = 4'b0000;
        wait_start(50, ok);
        n_cmp++; if (!ok || tx_data !== 8'h30) begin n_err++; $display("FAIL rstwait_first: ok=%0b data=%h want 30", ok, tx_data); end
        step();
        req_tick = 4'b0110;
        step();
        req_tick = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || grant !== 4'b0000 || busy !== 1'b0 || drop_tick !== 1'b0) begin
            n_err++; $display("FAIL rstwait_outputs: start=%b data=%h grant=%b busy=%b drop=%b want all 0", tx_start, tx_data, grant, busy, drop_tick);
        end
        s0 = start_cnt;
        step();
        pulse_done();
        steps(20);
        n_cmp++; if (start_cnt != s0) begin n_err++; $display("FAIL rstwait_no_start: got %0d starts want 0", start_cnt - s0); end
        n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_err++; $display("FAIL rstwait_idle: busy=%b grant=%b want 0/0000", busy, grant); end
        exp_q.delete();
        exp_g_q.delete();
    endtask

`ifdef BTN_TX_CRLF_EN
    task automatic test_crlf();
        logic [7:0] seq [3];
        bit ok;
        int s0;
        seq[0] = 8'h30;
        seq[1] = 8'h0D;
        seq[2] = 8'h0A;
        do_reset();
        s0 = start_cnt;
        req_tick = 4'b0001;
        step();
        req_tick = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            wait_start(50, ok);
            n_cmp++; if (!ok || tx_data !== seq[j] || grant !== 4'b0001) begin n_err++; $display("FAIL crlf_byte%0d: ok=%0b data=%h grant=%b want %h/0001", j, ok, tx_data, grant, seq[j]); end
            step();
            n_cmp++; if (busy !== 1'b1 || grant !== 4'b0001) begin n_err++; $display("FAIL crlf_hold%0d: busy=%b grant=%b want 1/0001", j, busy, grant); end
            pulse_done();
        end
        step();
        n_cmp++; if (busy !== 1'b0 || grant !== 4'b0000 || start_cnt - s0 != 3) begin n_err++; $display("FAIL crlf_end: busy=%b grant=%b starts=%0d want 0/0000/3", busy, grant, start_cnt - s0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_merge();
        test_reset_in_wait();
`ifdef BTN_TX_CRLF_EN
        test_crlf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
